ncl_add_sequencer: RTL and testbench

Clocked controller that sequences a WIDTH-bit dual-rail NCL ripple adder (a chain of full-adder cells) from a synchronous host. It accepts binary operands over a valid/ready handshake, drives them as dual-rail DATA wavefronts, and watches the adder's input completion and the dual-rail result. It then runs the NULL wavefront and returns the captured binary sum over a second valid/ready handshake. It sits between clocked test/host logic and the asynchronous adder array, and owns all return-to-NULL sequencing and hang detection.

---
 rtl/ncl_seq_pkg.sv | 25 ++
 rtl/ncl_sync2.sv | 23 ++
 rtl/ncl_add_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ncl_add_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_seq_pkg.sv
// Shared types and dual-rail helpers for the NCL adder sequencer.
package ncl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    W_NULL,
    OUT,
    ERR
  } state_t;

  // Dual-rail code as {rail1, rail0}
  localparam logic [1:0] DR_NULL  = 2'b00;
  localparam logic [1:0] DR_DATA0 = 2'b01;
  localparam logic [1:0] DR_DATA1 = 2'b10;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_DATA1 : DR_DATA0;
  endfunction

  function automatic logic dr_decode(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer bank for asynchronous status bits.
module ncl_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_add_sequencer.sv
// Clocked sequencer for a dual-rail NCL ripple adder: DATA wavefront, capture,
// NULL wavefront, result handshake, with timeout and illegal-code detection.
module ncl_add_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] ncl_a0,
  output logic [WIDTH-1:0] ncl_a1,
  output logic [WIDTH-1:0] ncl_b0,
  output logic [WIDTH-1:0] ncl_b1,
  output logic [1:0]       ncl_cin,
  input  logic             ncl_ackin,
  input  logic [WIDTH-1:0] ncl_sum0,
  input  logic [WIDTH-1:0] ncl_sum1,
  input  logic [1:0]       ncl_cout,
  output logic             ncl_sumcomp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t state, state_n;

  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a0_n, a1_n, b0_n, b1_n, sum_n;
  logic [1:0]       cin_n;
  logic             sumcomp_n, in_ready_n, out_valid_n, cout_n, err_n;

  // Raw result decode on the asynchronous rails
  logic cmp_c, nul_c, ill_c;
  logic ack_s, cmp_s, nul_s, ill_s;

  always_comb begin
    cmp_c = (&(ncl_sum0 ^ ncl_sum1)) & (ncl_cout[0] ^ ncl_cout[1]);
    nul_c = ~|{ncl_sum0, ncl_sum1, ncl_cout};
    ill_c = (|(ncl_sum0 & ncl_sum1)) | (&ncl_cout);
  end

  ncl_sync2 #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (init),
    .d   ({ill_c, nul_c, cmp_c, ncl_ackin}),
    .q   ({ill_s, nul_s, cmp_s, ack_s})
  );

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state       <= IDLE;
      cnt         <= '0;
      ncl_a0      <= '0;
      ncl_a1      <= '0;
      ncl_b0      <= '0;
      ncl_b1      <= '0;
      ncl_cin     <= DR_NULL;
      ncl_sumcomp <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      sum_out     <= '0;
      cout_out    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ncl_a0      <= a0_n;
      ncl_a1      <= a1_n;
      ncl_b0      <= b0_n;
      ncl_b1      <= b1_n;
      ncl_cin     <= cin_n;
      ncl_sumcomp <= sumcomp_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      sum_out     <= sum_n;
      cout_out    <= cout_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    a0_n        = ncl_a0;
    a1_n        = ncl_a1;
    b0_n        = ncl_b0;
    b1_n        = ncl_b1;
    cin_n       = ncl_cin;
    sumcomp_n   = ncl_sumcomp;
    in_ready_n  = 1'b0;
    out_valid_n = out_valid;
    sum_n       = sum_out;
    cout_n      = cout_out;
    err_n       = err;

    unique case (state)
      IDLE: begin
        in_ready_n = 1'b1;
        if (in_valid && in_ready) begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            {a1_n[i], a0_n[i]} = dr_encode(a_in[i]);
            {b1_n[i], b0_n[i]} = dr_encode(b_in[i]);
          end
          cin_n      = dr_encode(cin_in);
          in_ready_n = 1'b0;
          cnt_n      = '0;
          state_n    = W_DATA;
        end
      end
      W_DATA: begin
        cnt_n = cnt + CW'(1);
        if (ill_s) begin
          state_n = ERR;
        end else if (ack_s && cmp_s) begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            sum_n[i] = dr_decode({ncl_sum1[i], ncl_sum0[i]});
          end
          cout_n    = dr_decode(ncl_cout);
          sumcomp_n = 1'b1;
          a0_n      = '0;
          a1_n      = '0;
          b0_n      = '0;
          b1_n      = '0;
          cin_n     = DR_NULL;
          cnt_n     = '0;
          state_n   = W_NULL;
        end else if (cnt == CW'(TIMEOUT)) begin
          state_n = ERR;
        end
      end
      W_NULL: begin
        cnt_n = cnt + CW'(1);
        if (ill_s) begin
          state_n = ERR;
        end else if (!ack_s && nul_s) begin
          sumcomp_n   = 1'b0;
          out_valid_n = 1'b1;
          state_n     = OUT;
        end else if (cnt == CW'(TIMEOUT)) begin
          state_n = ERR;
        end
      end
      OUT: begin
        if (ill_s) begin
          state_n = ERR;
        end else if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: begin
        state_n = ERR;
      end
    endcase

    // Error entry parks the adder in NULL and holds off the host
    if (state_n == ERR) begin
      a0_n        = '0;
      a1_n        = '0;
      b0_n        = '0;
      b1_n        = '0;
      cin_n       = DR_NULL;
      sumcomp_n   = 1'b0;
      in_ready_n  = 1'b0;
      out_valid_n = 1'b0;
      cnt_n       = '0;
      err_n       = 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Scoreboard bench for ncl_add_sequencer with a 3-cycle behavioral NCL adder.
module tb_ncl_add_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         init = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic [W-1:0] ncl_a0, ncl_a1, ncl_b0, ncl_b1;
  logic [1:0]   ncl_cin;
  logic         ncl_ackin;
  logic [W-1:0] ncl_sum0, ncl_sum1;
  logic [1:0]   ncl_cout;
  logic         ncl_sumcomp;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         err;

  always #5 clk = ~clk;

  ncl_add_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .init        (init),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin_in      (cin_in),
    .ncl_a0      (ncl_a0),
    .ncl_a1      (ncl_a1),
    .ncl_b0      (ncl_b0),
    .ncl_b1      (ncl_b1),
    .ncl_cin     (ncl_cin),
    .ncl_ackin   (ncl_ackin),
    .ncl_sum0    (ncl_sum0),
    .ncl_sum1    (ncl_sum1),
    .ncl_cout    (ncl_cout),
    .ncl_sumcomp (ncl_sumcomp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum_out     (sum_out),
    .cout_out    (cout_out),
    .err         (err)
  );

  // Adder model: 0 normal, 1 never acknowledges, 2 drives bit 3 on both rails
  int mode = 0;

  typedef struct packed {
    logic         ack;
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [1:0]   co;
  } resp_t;

  resp_t      f;
  resp_t      d1 = '0;
  resp_t      d2 = '0;
  resp_t      d3 = '0;
  logic [W:0] m_s;
  logic       m_data;

  always_comb begin
    m_data = (&(ncl_a0 ^ ncl_a1)) & (&(ncl_b0 ^ ncl_b1)) & (ncl_cin[0] ^ ncl_cin[1]);
    m_s    = {1'b0, ncl_a1} + {1'b0, ncl_b1} + {{W{1'b0}}, ncl_cin[1]};
    f      = '0;
    f.ack  = (mode != 1) && (|{ncl_a0, ncl_a1, ncl_b0, ncl_b1, ncl_cin});
    if (m_data) begin
      f.s1 = m_s[W-1:0];
      f.s0 = ~m_s[W-1:0];
      f.co = {m_s[W], ~m_s[W]};
      if (mode == 2) begin
        f.s1[3] = 1'b1;
        f.s0[3] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    d1 <= f;
    d2 <= d1;
    d3 <= d2;
  end

  assign ncl_ackin = d3.ack;
  assign ncl_sum0  = d3.s0;
  assign ncl_sum1  = d3.s1;
  assign ncl_cout  = d3.co;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers = 0;
  int sc_rises = 0;
  logic sc_prev = 1'b0;
  logic [W:0] sb[$];
  logic [W:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every accepted result is popped and compared here
  always @(negedge clk) begin
    if (!init && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(sum_out), 32'hFFFF_FFFF);
      end else begin
        mon_exp = sb.pop_front();
        chk("sum_out", 32'(sum_out), 32'(mon_exp[W-1:0]));
        chk("cout_out", 32'(cout_out), 32'(mon_exp[W]));
        chk("rails_null_at_out", 32'(|{ncl_a0, ncl_a1, ncl_b0, ncl_b1, ncl_cin}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ncl_sumcomp && !sc_prev) sc_rises++;
    sc_prev = ncl_sumcomp;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic push, input logic [W:0] exp, output int acc);
    int n;
    @(negedge clk);
    a_in = a;
    b_in = b;
    cin_in = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    if (push) sb.push_back(exp);
  endtask

  // sel 0: out_valid, sel 1: err; lat = edges since accept, -1 on timeout
  task automatic wait_for(input int sel, input int acc, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 60) begin
      @(negedge clk);
      if ((sel == 0 && out_valid) || (sel == 1 && err)) begin
        lat = cyc - acc;
        break;
      end
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rails"}, 32'(|{ncl_a0, ncl_a1, ncl_b0, ncl_b1, ncl_cin}), 32'd0);
    chk({tag, "_sumcomp"}, 32'(ncl_sumcomp), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum_out"}, 32'(sum_out), 32'd0);
    chk({tag, "_cout_out"}, 32'(cout_out), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_init(input string tag);
    @(negedge clk);
    #2;
    init = 1'b1;
    #1;
    check_reset(tag);
    mode = 0;
    repeat (6) @(negedge clk);
    init = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, sc0, x0, n;
    logic [W-1:0] hold;

    repeat (3) @(negedge clk);
    check_reset("por");
    init = 1'b0;
    repeat (2) @(negedge clk);

    // Basic add with latency and single sumcomp pulse
    sc0 = sc_rises;
    send(8'h5A, 8'h33, 1'b0, 1'b1, {1'b0, 8'h8D}, acc);
    wait_for(0, acc, lat);
    chk("first_out_latency", 32'(lat), 32'd12);
    @(negedge clk);
    chk("in_ready_after_xfer", 32'(in_ready), 32'd1);
    chk("out_valid_after_xfer", 32'(out_valid), 32'd0);
    chk("sumcomp_pulses", 32'(sc_rises - sc0), 32'd1);
    chk("err_clean", 32'(err), 32'd0);

    // Full carry chain
    send(8'hFF, 8'h01, 1'b1, 1'b1, {1'b1, 8'h01}, acc);
    wait_for(0, acc, lat);
    chk("carry_latency", 32'(lat), 32'd12);
    repeat (2) @(negedge clk);

    // Backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    send(8'h7F, 8'h80, 1'b1, 1'b1, {1'b1, 8'h00}, acc);
    wait_for(0, acc, lat);
    chk("hold_out_seen", 32'(lat), 32'd12);
    hold = sum_out;
    x0 = xfers;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum_stable", 32'(sum_out), 32'(hold));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_one_transfer", 32'(xfers - x0), 32'd1);
    chk("hold_released", 32'(out_valid), 32'd0);

    // Adder never acknowledges: timeout after TO+1 cycles in W_DATA
    mode = 1;
    send(8'hC3, 8'h3C, 1'b0, 1'b0, '0, acc);
    wait_for(1, acc, lat);
    chk("timeout_latency", 32'(lat), 32'd16);
    chk("timeout_rails_null", 32'(|{ncl_a0, ncl_a1, ncl_b0, ncl_b1, ncl_cin}), 32'd0);
    chk("timeout_sumcomp", 32'(ncl_sumcomp), 32'd0);
    chk("timeout_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_in_ready", 32'(in_ready), 32'd0);
    end
    do_init("init_after_timeout");

    // Illegal rail code on sum bit 3
    mode = 2;
    send(8'hC3, 8'h3C, 1'b0, 1'b0, '0, acc);
    wait_for(1, acc, lat);
    chk("illegal_latency", 32'(lat), 32'd6);
    chk("illegal_rails_null", 32'(|{ncl_a0, ncl_a1, ncl_b0, ncl_b1, ncl_cin}), 32'd0);
    chk("illegal_in_ready", 32'(in_ready), 32'd0);
    do_init("init_after_illegal");

    // Recovery after error
    send(8'hC3, 8'h3C, 1'b0, 1'b1, {1'b0, 8'hFF}, acc);
    wait_for(0, acc, lat);
    chk("recover_latency", 32'(lat), 32'd12);
    repeat (2) @(negedge clk);

    // init during W_NULL, then a fresh transaction
    send(8'h12, 8'h34, 1'b0, 1'b1, {1'b0, 8'h46}, acc);
    n = 0;
    while (!ncl_sumcomp && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reached_w_null", 32'(ncl_sumcomp), 32'd1);
    sb.delete();
    do_init("init_mid_null");
    send(8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 8'h30}, acc);
    wait_for(0, acc, lat);
    chk("post_init_latency", 32'(lat), 32'd12);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
